// File: rtl/mem_access.sv
// mem_access -- memory-access stage of the eCPU RV32I pipeline.
//
// Takes the EX/MEM pipeline register contents, drives a req/gnt/rvalid
// data-memory port, aligns store data into byte lanes, sign/zero-extends
// load data and registers the result into the MEM/WB pipeline register.
// Upstream stages are held via stall_o while a transaction is in flight.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   pc_i/instr_i/instr_valid_i   instruction from EX
//   rd_addr_i                    destination register
//   alu_result_i                 ALU result or effective address
//   rs2_data_i                   store data
//   reg_write_i/mem_read_i/mem_write_i  control
//   mem_size_i                   funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   fwd_data_o                   alu_result_i passthrough for EX forwarding
//   stall_o                      holds EX and earlier stages
//   dmem_*                       data-memory request/response port
//   pc_o/instr_o/instr_valid_o/rd_addr_o/rd_data_o/reg_write_o/misalign_o
//                                MEM/WB pipeline register

module mem_access #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ILEN           = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [ADDR_WIDTH-1:0]     pc_i,
  input  logic [ILEN-1:0]           instr_i,
  input  logic                      instr_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [XLEN-1:0]           alu_result_i,
  input  logic [XLEN-1:0]           rs2_data_i,
  input  logic                      reg_write_i,
  input  logic                      mem_read_i,
  input  logic                      mem_write_i,
  input  logic [2:0]                mem_size_i,
  output logic [XLEN-1:0]           fwd_data_o,
  output logic                      stall_o,
  output logic                      dmem_req_o,
  output logic                      dmem_we_o,
  output logic [ADDR_WIDTH-1:0]     dmem_addr_o,
  output logic [XLEN-1:0]           dmem_wdata_o,
  output logic [3:0]                dmem_be_o,
  input  logic                      dmem_gnt_i,
  input  logic                      dmem_rvalid_i,
  input  logic [XLEN-1:0]           dmem_rdata_i,
  output logic [ADDR_WIDTH-1:0]     pc_o,
  output logic [ILEN-1:0]           instr_o,
  output logic                      instr_valid_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic [XLEN-1:0]           rd_data_o,
  output logic                      reg_write_o,
  output logic                      misalign_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  // Transaction fields latched when a request is launched
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [XLEN-1:0]       r_wdata;
  logic [2:0]            r_size;
  logic [1:0]            r_off;

  logic                  w_mem_op;
  logic                  w_misaligned;
  logic                  w_aligned_op;
  logic [3:0]            w_be;
  logic [XLEN-1:0]       w_wdata;
  logic [XLEN-1:0]       w_rshift;
  logic [XLEN-1:0]       w_load;
  logic                  w_stall;

  assign fwd_data_o = alu_result_i;

  assign w_mem_op     = instr_valid_i && (mem_read_i || mem_write_i);
  assign w_misaligned = w_mem_op &&
                        (((mem_size_i[1:0] == 2'b01) && alu_result_i[0]) ||
                         ((mem_size_i[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00)));
  assign w_aligned_op = w_mem_op && !w_misaligned;

  // Store lane placement; loads never assert byte enables
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = rs2_data_i;
    case (mem_size_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << alu_result_i[1:0];
        w_wdata = {4{rs2_data_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {alu_result_i[1], 1'b0};
        w_wdata = {2{rs2_data_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = rs2_data_i;
      end
    endcase
    if (!mem_write_i) begin
      w_be = '0;
    end
  end

  // Load extraction from the latched byte offset and size
  assign w_rshift = dmem_rdata_i >> {r_off, 3'b000};

  always_comb begin
    w_load = w_rshift;
    case (r_size)
      3'b000:  w_load = {{24{w_rshift[7]}}, w_rshift[7:0]};
      3'b001:  w_load = {{16{w_rshift[15]}}, w_rshift[15:0]};
      3'b100:  w_load = {24'd0, w_rshift[7:0]};
      3'b101:  w_load = {16'd0, w_rshift[15:0]};
      default: w_load = w_rshift;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_aligned_op) w_state_nxt = S_REQ;
      S_REQ:  if (dmem_gnt_i)   w_state_nxt = r_we ? S_IDLE : S_WAIT;
      S_WAIT: if (dmem_rvalid_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    w_stall    = 1'b0;
    case (r_state)
      S_IDLE: w_stall = w_aligned_op;
      S_REQ: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = r_we;
        w_stall    = !(dmem_gnt_i && r_we);
      end
      S_WAIT: w_stall = !dmem_rvalid_i;
      default: w_stall = 1'b0;
    endcase
  end

  assign stall_o      = w_stall;
  assign dmem_addr_o  = r_addr;
  assign dmem_wdata_o = r_wdata;
  assign dmem_be_o    = r_be;

  // Latch the request fields when an aligned access is launched from IDLE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_off   <= '0;
    end else if ((r_state == S_IDLE) && w_aligned_op) begin
      r_addr  <= {alu_result_i[ADDR_WIDTH-1:2], 2'b00};
      r_we    <= mem_write_i;
      r_be    <= w_be;
      r_wdata <= w_wdata;
      r_size  <= mem_size_i;
      r_off   <= alu_result_i[1:0];
    end
  end

  // MEM/WB register: loads when not stalled, otherwise a bubble is inserted.
  // The only unstalled edge for an aligned load is WAIT with rvalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_o          <= '0;
      instr_o       <= '0;
      instr_valid_o <= 1'b0;
      rd_addr_o     <= '0;
      rd_data_o     <= '0;
      reg_write_o   <= 1'b0;
      misalign_o    <= 1'b0;
    end else if (!w_stall) begin
      pc_o          <= pc_i;
      instr_o       <= instr_i;
      instr_valid_o <= instr_valid_i;
      rd_addr_o     <= rd_addr_i;
      rd_data_o     <= (r_state == S_WAIT) ? w_load : alu_result_i;
      reg_write_o   <= reg_write_i && instr_valid_i && !w_misaligned;
      misalign_o    <= w_misaligned;
    end else begin
      instr_valid_o <= 1'b0;
      reg_write_o   <= 1'b0;
      misalign_o    <= 1'b0;
    end
  end

endmodule
